// File: rtl/osyrys64_pkg.sv
// osyrys64_pkg: shared types for the NPU dispatch sequencer.
//   npu_op_t             - NPU operation encoding carried with each command
//   npu_dispatch_state_t - dispatch FSM state encoding
//   npu_cmd_entry_t      - one queued command: op, operands, destination register
package osyrys64_pkg;

    localparam int NPU_TAG_W = 3;
    localparam int NPU_XLEN  = 64;

    typedef enum logic [1:0] {
        NPU_OP_NONE   = 2'd0,
        NPU_OP_MATMUL = 2'd1,
        NPU_OP_CONV   = 2'd2
    } npu_op_t;

    typedef enum logic [1:0] {
        NPU_ST_IDLE = 2'd0,
        NPU_ST_SEND = 2'd1,
        NPU_ST_WAIT = 2'd2
    } npu_dispatch_state_t;

    typedef struct packed {
        npu_op_t             op;
        logic [NPU_XLEN-1:0] a;
        logic [NPU_XLEN-1:0] b;
        logic [4:0]          rd;
    } npu_cmd_entry_t;

    // Exactly one strobe selects an op; anything else decodes to NONE.
    function automatic npu_op_t npu_decode_op(input logic is_mm, input logic is_conv);
        npu_op_t op;
        case ({is_mm, is_conv})
            2'b10:   op = NPU_OP_MATMUL;
            2'b01:   op = NPU_OP_CONV;
            default: op = NPU_OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/npu_dispatch_cmd_fifo.sv
// npu_cmd_fifo: synchronous FIFO of command entries with a registered
// occupancy count. Push at full and pop at empty are ignored internally.
module npu_cmd_fifo #(
    parameter type entry_t = logic,
    parameter int  DEPTH   = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally for power-of-two depth.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/npu_dispatch.sv
// npu_dispatch: queues decoded NPU instructions, issues them one at a time
// over a valid/ready command channel with a rolling tag, and retires a
// one-cycle register writeback when the matching tagged response returns.
// Optional: define NPU_DISPATCH_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
//
// state | meaning
// IDLE  | nothing in flight, waiting for the queue to fill
// SEND  | head entry presented on the command channel
// WAIT  | command accepted, waiting for the response carrying its tag
module npu_dispatch
    import osyrys64_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic                 is_npu_matrix_mul,
    input  logic                 is_npu_conv,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [4:0]           rd_addr,
    output logic                 issue_ready,
    output logic                 npu_cmd_valid,
    output npu_op_t              npu_cmd_op,
    output logic [XLEN-1:0]      npu_cmd_a,
    output logic [XLEN-1:0]      npu_cmd_b,
    output logic [NPU_TAG_W-1:0] npu_cmd_tag,
    input  logic                 npu_cmd_ready,
    input  logic                 npu_rsp_valid,
    input  logic [NPU_TAG_W-1:0] npu_rsp_tag,
    input  logic [XLEN-1:0]      npu_rsp_data,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 busy,
    output logic                 timeout_err
);

    // Entry operands are sized by the package; the instance must agree.
    if (XLEN != NPU_XLEN) begin : g_bad_xlen
        $error("npu_dispatch: XLEN must equal NPU_XLEN");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("npu_dispatch: TIMEOUT must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("npu_dispatch: DEPTH must be a power of two >= 2");
    end

    npu_dispatch_state_t  state_q, state_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [NPU_TAG_W-1:0] tag_q, tag_d;
    logic [NPU_TAG_W-1:0] wtag_q, wtag_d;
    logic [4:0]           wrd_q, wrd_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [4:0]           wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]      wb_data_q, wb_data_d;

    npu_cmd_entry_t       push_entry, fifo_head;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                 rsp_hit, has_next;

`ifdef NPU_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 tmo_err_q, tmo_err_d;
`endif

    assign fifo_push  = issue_valid && issue_ready && (is_npu_matrix_mul ^ is_npu_conv);
    assign fifo_pop   = (state_q == NPU_ST_SEND) && npu_cmd_ready;
    assign push_entry = '{op: npu_decode_op(is_npu_matrix_mul, is_npu_conv),
                          a:  rs1_data,
                          b:  rs2_data,
                          rd: rd_addr};

    npu_cmd_fifo #(
        .entry_t (npu_cmd_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // WAIT never pops, so a same-cycle push is the only way the queue gains an entry.
    assign rsp_hit  = (state_q == NPU_ST_WAIT) && npu_rsp_valid && (npu_rsp_tag == wtag_q);
    assign has_next = !fifo_empty || fifo_push;

    // Command fields come straight from the FIFO head, which only moves on accept.
    assign issue_ready   = !fifo_full;
    assign npu_cmd_valid = cmd_valid_q;
    assign npu_cmd_op    = cmd_valid_q ? fifo_head.op : NPU_OP_NONE;
    assign npu_cmd_a     = cmd_valid_q ? fifo_head.a  : '0;
    assign npu_cmd_b     = cmd_valid_q ? fifo_head.b  : '0;
    assign npu_cmd_tag   = cmd_valid_q ? tag_q        : '0;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign busy          = (state_q != NPU_ST_IDLE) || !fifo_empty;
`ifdef NPU_DISPATCH_TIMEOUT_EN
    assign timeout_err   = tmo_err_q;
`else
    assign timeout_err   = 1'b0;
`endif

    // Next-state and registered-output logic for the dispatch sequencer.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        tag_d       = tag_q;
        wtag_d      = wtag_q;
        wrd_d       = wrd_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
`ifdef NPU_DISPATCH_TIMEOUT_EN
        tmo_d       = tmo_q;
        tmo_err_d   = tmo_err_q;
`endif
        case (state_q)
            NPU_ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d     = NPU_ST_SEND;
                    cmd_valid_d = 1'b1;
                end
            end
            NPU_ST_SEND: begin
                if (npu_cmd_ready) begin
                    state_d     = NPU_ST_WAIT;
                    cmd_valid_d = 1'b0;
                    wrd_d       = fifo_head.rd;
                    wtag_d      = tag_q;
                    tag_d       = tag_q + 1'b1;
`ifdef NPU_DISPATCH_TIMEOUT_EN
                    tmo_d       = TW'(TIMEOUT - 1);
`endif
                end
            end
            NPU_ST_WAIT: begin
                if (rsp_hit) begin
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = wrd_q;
                    wb_data_d   = npu_rsp_data;
                    state_d     = has_next ? NPU_ST_SEND : NPU_ST_IDLE;
                    cmd_valid_d = has_next;
                end
`ifdef NPU_DISPATCH_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    tmo_err_d   = 1'b1;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = wrd_q;
                    wb_data_d   = '0;
                    state_d     = has_next ? NPU_ST_SEND : NPU_ST_IDLE;
                    cmd_valid_d = has_next;
                end else begin
                    tmo_d       = tmo_q - 1'b1;
                end
`endif
            end
            default: begin
                state_d     = NPU_ST_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset abandons any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NPU_ST_IDLE;
            cmd_valid_q <= 1'b0;
            tag_q       <= '0;
            wtag_q      <= '0;
            wrd_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
`ifdef NPU_DISPATCH_TIMEOUT_EN
            tmo_q       <= '0;
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            tag_q       <= tag_d;
            wtag_q      <= wtag_d;
            wrd_q       <= wrd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
`ifdef NPU_DISPATCH_TIMEOUT_EN
            tmo_q       <= tmo_d;
            tmo_err_q   <= tmo_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_npu_dispatch.sv
// tb_npu_dispatch: directed scenarios for npu_dispatch with scoreboard queues
// of expected commands and writebacks.
module tb_npu_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        is_npu_matrix_mul = 1'b0;
    logic        is_npu_conv = 1'b0;
    logic [63:0] rs1_data = '0;
    logic [63:0] rs2_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        issue_ready;
    logic        npu_cmd_valid;
    logic [1:0]  npu_cmd_op;
    logic [63:0] npu_cmd_a;
    logic [63:0] npu_cmd_b;
    logic [2:0]  npu_cmd_tag;
    logic        npu_cmd_ready = 1'b0;
    logic        npu_rsp_valid = 1'b0;
    logic [2:0]  npu_rsp_tag = '0;
    logic [63:0] npu_rsp_data = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        busy;
    logic        timeout_err;

    npu_dispatch #(.XLEN(64), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .issue_valid       (issue_valid),
        .is_npu_matrix_mul (is_npu_matrix_mul),
        .is_npu_conv       (is_npu_conv),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .rd_addr           (rd_addr),
        .issue_ready       (issue_ready),
        .npu_cmd_valid     (npu_cmd_valid),
        .npu_cmd_op        (npu_cmd_op),
        .npu_cmd_a         (npu_cmd_a),
        .npu_cmd_b         (npu_cmd_b),
        .npu_cmd_tag       (npu_cmd_tag),
        .npu_cmd_ready     (npu_cmd_ready),
        .npu_rsp_valid     (npu_rsp_valid),
        .npu_rsp_tag       (npu_rsp_tag),
        .npu_rsp_data      (npu_rsp_data),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  tag;
    } exp_cmd_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_wb_t;

    exp_cmd_t cmd_q[$];
    exp_wb_t  wb_q[$];
    logic [2:0] nxt_tag = '0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted command and every writeback must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (npu_cmd_valid && npu_cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", {63'd0, npu_cmd_valid}, 64'd0);
                end else begin
                    exp_cmd_t e;
                    e = cmd_q.pop_front();
                    chk("cmd_op",  {62'd0, npu_cmd_op}, {62'd0, e.op});
                    chk("cmd_a",   npu_cmd_a, e.a);
                    chk("cmd_b",   npu_cmd_b, e.b);
                    chk("cmd_tag", {61'd0, npu_cmd_tag}, {61'd0, e.tag});
                end
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", {63'd0, wb_valid}, 64'd0);
                end else begin
                    exp_wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_rd",   {59'd0, wb_rd}, {59'd0, w.rd});
                    chk("wb_data", wb_data, w.data);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        is_npu_matrix_mul = 1'b0;
        is_npu_conv = 1'b0;
        npu_cmd_ready = 1'b0;
        npu_rsp_valid = 1'b0;
        cmd_q.delete();
        wb_q.delete();
        nxt_tag = '0;
        #1;
        chk("rst_async_cmd_valid", {63'd0, npu_cmd_valid}, 64'd0);
        chk("rst_async_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
        chk("rst_cmd_valid",   {63'd0, npu_cmd_valid}, 64'd0);
        chk("rst_cmd_op",      {62'd0, npu_cmd_op}, 64'd0);
        chk("rst_cmd_a",       npu_cmd_a, 64'd0);
        chk("rst_cmd_b",       npu_cmd_b, 64'd0);
        chk("rst_cmd_tag",     {61'd0, npu_cmd_tag}, 64'd0);
        chk("rst_wb_valid",    {63'd0, wb_valid}, 64'd0);
        chk("rst_wb_rd",       {59'd0, wb_rd}, 64'd0);
        chk("rst_wb_data",     wb_data, 64'd0);
        chk("rst_busy",        {63'd0, busy}, 64'd0);
        chk("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    endtask

    // One-cycle issue; caller states whether issue_ready is expected and whether it pushes.
    task automatic issue(input bit mm, input bit cv, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input bit exp_ready, input bit exp_push);
        exp_cmd_t e;
        issue_valid = 1'b1;
        is_npu_matrix_mul = mm;
        is_npu_conv = cv;
        rs1_data = a;
        rs2_data = b;
        rd_addr = rd;
        chk("issue_ready", {63'd0, issue_ready}, {63'd0, exp_ready});
        if (exp_push) begin
            e.op = mm ? 2'd1 : 2'd2;
            e.a = a;
            e.b = b;
            e.tag = nxt_tag;
            cmd_q.push_back(e);
            nxt_tag = nxt_tag + 3'd1;
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        is_npu_matrix_mul = 1'b0;
        is_npu_conv = 1'b0;
    endtask

    // Wait (bounded) for a command handshake; returns just after the accepting edge.
    task automatic wait_cmd();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (npu_cmd_valid && npu_cmd_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("cmd_handshake_seen", {63'd0, got}, 64'd1);
    endtask

    task automatic respond(input logic [2:0] tag, input logic [63:0] data,
                           input bit exp_wb, input logic [4:0] rd);
        exp_wb_t w;
        npu_rsp_valid = 1'b1;
        npu_rsp_tag = tag;
        npu_rsp_data = data;
        if (exp_wb) begin
            w.rd = rd;
            w.data = data;
            wb_q.push_back(w);
        end
        @(posedge clk);
        #1;
        npu_rsp_valid = 1'b0;
        chk("wb_latency", {63'd0, wb_valid}, {63'd0, exp_wb});
    endtask

    initial begin
        // Reset values
        do_reset();
        check_reset_outputs();

        // Single matmul with 2-cycle issue latency and registered writeback
        npu_cmd_ready = 1'b1;
        issue(1'b1, 1'b0, 64'd5, 64'd7, 5'd3, 1'b1, 1'b1);
        chk("issue_latency_pre", {63'd0, npu_cmd_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("issue_latency", {63'd0, npu_cmd_valid}, 64'd1);
        wait_cmd();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        respond(3'd0, 64'd35, 1'b1, 5'd3);
        @(posedge clk);
        #1;
        chk("wb_one_cycle", {63'd0, wb_valid}, 64'd0);
        chk("busy_after_single", {63'd0, busy}, 64'd0);

        // Fill to full with the NPU stalled; fifth issue refused
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(i[0] == 1'b0, i[0] == 1'b1, 64'h100 + 64'(i), 64'h200 + 64'(i),
                  5'(10 + i), i < 4, i < 4);
        end
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {63'd0, npu_cmd_valid}, 64'd1);
            chk("stall_a", npu_cmd_a, 64'h100);
            chk("stall_tag", {61'd0, npu_cmd_tag}, 64'd0);
            chk("stall_full", {63'd0, issue_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        npu_cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cmd();
            respond(3'(i), 64'h1000 + 64'(i), 1'b1, 5'(10 + i));
        end
        @(posedge clk);
        #1;
        chk("busy_after_drain", {63'd0, busy}, 64'd0);

        // Mismatched tag ignored, matching tag retires
        do_reset();
        npu_cmd_ready = 1'b1;
        issue(1'b0, 1'b1, 64'd2, 64'd3, 5'd9, 1'b1, 1'b1);
        wait_cmd();
        respond(3'd5, 64'd77, 1'b0, 5'd0);
        respond(3'd0, 64'd88, 1'b1, 5'd9);

        // Both strobes / no strobe: dropped
        do_reset();
        npu_cmd_ready = 1'b1;
        issue(1'b1, 1'b1, 64'd1, 64'd1, 5'd1, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 64'd2, 64'd2, 5'd2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drop_no_valid", {63'd0, npu_cmd_valid}, 64'd0);
            chk("drop_not_busy", {63'd0, busy}, 64'd0);
            @(posedge clk);
            #1;
        end

        // Timeout abort (feature build) or indefinite WAIT (default build)
        do_reset();
        npu_cmd_ready = 1'b1;
`ifdef NPU_DISPATCH_TIMEOUT_EN
        issue(1'b1, 1'b0, 64'd1, 64'd2, 5'd4, 1'b1, 1'b1);
        issue(1'b0, 1'b1, 64'd3, 64'd4, 5'd6, 1'b1, 1'b1);
        wait_cmd();
        begin
            exp_wb_t w;
            w.rd = 5'd4;
            w.data = 64'd0;
            wb_q.push_back(w);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            chk("tmo_wait_no_wb", {63'd0, wb_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        chk("tmo_wb", {63'd0, wb_valid}, 64'd1);
        chk("tmo_err_set", {63'd0, timeout_err}, 64'd1);
        wait_cmd();
        respond(3'd1, 64'h77, 1'b1, 5'd6);
        chk("tmo_err_sticky", {63'd0, timeout_err}, 64'd1);
`else
        issue(1'b1, 1'b0, 64'd1, 64'd2, 5'd4, 1'b1, 1'b1);
        wait_cmd();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            chk("hold_wait_no_wb", {63'd0, wb_valid}, 64'd0);
        end
        chk("hold_wait_busy", {63'd0, busy}, 64'd1);
        chk("no_timeout_err", {63'd0, timeout_err}, 64'd0);
`endif

        // Reset in WAIT with two queued entries
        do_reset();
        npu_cmd_ready = 1'b1;
        issue(1'b1, 1'b0, 64'h11, 64'h12, 5'd1, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 64'h21, 64'h22, 5'd2, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 64'h31, 64'h32, 5'd3, 1'b1, 1'b1);
        chk("midop_busy", {63'd0, busy}, 64'd1);
        chk("midop_in_wait", {63'd0, npu_cmd_valid}, 64'd0);
        do_reset();
        check_reset_outputs();
        respond(3'd0, 64'hdead, 1'b0, 5'd0);
        npu_cmd_ready = 1'b1;
        issue(1'b0, 1'b1, 64'h9, 64'h9, 5'd7, 1'b1, 1'b1);
        wait_cmd();
        respond(3'd0, 64'h55, 1'b1, 5'd7);
        @(posedge clk);
        #1;

        chk("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        chk("wb_q_drained", 64'(wb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/npu_dispatch.md
# npu_dispatch

Sequencer between the decode stage and the NPU. Decoded NPU instructions, flagged by the matrix-multiply and convolution strobes, are queued with their operands and destination register, then issued to the NPU over a valid/ready command channel. Each command gets a rolling tag, and the block waits for the tagged response before retiring a one-cycle register writeback. Only one NPU operation is in flight at a time; the queue absorbs bursts so decode stalls only when it is full.

## Interface
- XLEN, 64, operand and result width
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 1024, cycles allowed in WAIT before abort (≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  decode presents an NPU instruction
- is_npu_matrix_mul  in  1  decoded matrix-multiply strobe
- is_npu_conv  in  1  decoded convolution strobe
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B
- rd_addr  in  5  destination register
- issue_ready  out  1  FIFO not full (count < DEPTH)
- npu_cmd_valid  out  1  command presented to NPU
- npu_cmd_op  out  npu_op_t  NPU_OP_MATMUL / NPU_OP_CONV
- npu_cmd_a  out  XLEN  operand A of head entry
- npu_cmd_b  out  XLEN  operand B of head entry
- npu_cmd_tag  out  NPU_TAG_W  tag of presented command
- npu_cmd_ready  in  1  NPU accepts command
- npu_rsp_valid  in  1  NPU result valid
- npu_rsp_tag  in  NPU_TAG_W  tag of result
- npu_rsp_data  in  XLEN  result
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  XLEN  writeback value
- busy  out  1  FIFO non-empty or state != IDLE
- timeout_err  out  1  sticky abort flag

## Operation
- Push: issue_valid && issue_ready && exactly one strobe set. The entry is {op, rs1_data, rs2_data, rd_addr}. Both strobes set or neither set: no push, silently dropped.
- FSM states IDLE, SEND, WAIT:
  - IDLE: FIFO non-empty → SEND.
  - SEND: npu_cmd_valid=1, driving the head entry and the current tag. On npu_cmd_ready: pop the head, latch rd and tag, increment the tag counter, → WAIT.
  - WAIT: npu_rsp_valid && npu_rsp_tag == latched tag → wb_valid=1 with wb_rd=latched rd and wb_data=npu_rsp_data. Then → SEND if the FIFO is non-empty after this cycle, else → IDLE.
- Responses with a mismatched tag, or arriving outside WAIT, are ignored.
- Tag counter: NPU_TAG_W bits, wraps from max to 0.
- Simultaneous push and pop: count unchanged. issue_ready derives from the registered count, so there is no push at full even with a same-cycle pop.
- Command outputs are stable while npu_cmd_valid is high and ready is low.
- Reset, including mid-operation: state IDLE, FIFO emptied, tag 0, timeout counter 0, timeout_err 0. All outputs 0 except issue_ready=1. The in-flight command is abandoned, and any later response is ignored.

## Timing
- Push at edge k into an idle, empty block → npu_cmd_valid high in the cycle after edge k+1 (2-cycle issue latency).
- A matching response in cycle c → wb_valid high in cycle c+1 (registered), for exactly one cycle.
- Back-to-back: after writeback, the next queued command is presented in the cycle after the FSM's WAIT exit.
- busy is registered-state derived and has no combinational path from inputs.

## Configuration
- NPU_DISPATCH_TIMEOUT_EN defined:
  - A counter runs in WAIT. After TIMEOUT cycles without a matching response, set timeout_err (sticky until rst), emit wb_valid with wb_data=0, and leave WAIT as on a normal response.
  - A matching response in the expiry cycle wins; no error is flagged.
- Undefined: no counter. WAIT holds indefinitely and timeout_err is tied 0.

## Structure
- osyrys64_pkg holds:
  - npu_op_t (NPU_OP_NONE=0, NPU_OP_MATMUL=1, NPU_OP_CONV=2, 2 bits)
  - npu_dispatch_state_t
  - NPU_TAG_W=3
  - a packed npu_cmd_entry_t struct
- One sub-module: npu_cmd_fifo, a synchronous FIFO parameterized by entry type and DEPTH, with a registered count and full/empty flags.

## Test plan
- Single matmul: rs1=5, rs2=7, rd=3; NPU ready immediately, responds with tag 0 and data 35 after 4 cycles → one cmd with op=MATMUL, tag 0; wb_valid for one cycle with rd=3, data=35; busy low afterwards.
- Hold npu_cmd_ready low and issue 5 commands with DEPTH=4 → issue_ready low after 4 accepted; the 5th is not pushed; cmd outputs stable; draining yields tags 0,1,2,3 in FIFO order.
- In WAIT, respond with tag 5 then tag 0 → only the tag-0 response produces a writeback.
- Issue with both strobes set, then with neither → no push, count stays 0, npu_cmd_valid never asserts.
- With NPU_DISPATCH_TIMEOUT_EN, TIMEOUT=16 and no response → after 16 WAIT cycles timeout_err=1 and a wb pulse with data 0; the next queued command then issues normally.
- Assert rst while in WAIT with 2 entries queued → all outputs at reset values; a late response is ignored; a new issue then gets tag 0.
